uart_rx_param: RTL and testbench

Parametrised UART receive block. It converts an asynchronous serial line into parallel words and queues them in a small FIFO for downstream logic, with a valid/ready output handshake. It extends the existing fixed 8N1 receiver in several ways: configurable data width, parity and stop bits; majority-vote bit sampling; and start-bit glitch rejection. It also reports framing, parity and overrun errors per word.

---
 rtl/uart_rx_param.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote sampling, start-glitch rejection,
// optional parity, 1/2 stop bits, and a small receive FIFO with per-word error flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle; waits for rx_s low while armed
// S_START | start bit; a majority-high sample is rejected as a glitch
// S_DATA  | shifting data bits in, LSB first
// S_PARITY| checking the parity bit
// S_STOP  | checking stop bit(s); pushes the word at the final sample
module uart_rx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  frame_err_o,
  output logic                  parity_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam int BW         = $clog2(DATA_WIDTH);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int EW         = DATA_WIDTH + 2;

  localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1   = CW'(HALF);
  localparam logic [CW-1:0] C_S2   = CW'(HALF + 1);
  localparam logic [CW-1:0] C_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   C_DEPTH    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_sync1, r_sync2;
  logic [CW-1:0]         r_cnt;
  logic                  r_s0, r_s1;
  logic [BW-1:0]         r_bit_idx;
  logic                  r_stop_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_frame_err, r_par_err;
  logic                  r_armed;

  logic                  w_rx_s, w_maj, w_sample, w_bit_end;
  logic                  w_last_stop, w_par_exp, w_frame_err_fin, w_push;

  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [AW:0]           r_count;
  logic                  r_overrun;
  logic                  w_full, w_empty, w_pop, w_wr;
  logic [EW-1:0]         w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s          = r_sync2;
  assign w_maj           = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign w_sample        = (r_cnt == C_S2);
  assign w_bit_end       = (r_cnt == C_LAST);
  assign w_last_stop     = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
  assign w_par_exp       = (^r_shift) ^ ((PARITY == 1) ? 1'b1 : 1'b0);
  assign w_frame_err_fin = r_frame_err | (w_sample & ~w_maj);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:   if (r_armed && !w_rx_s) w_state_nxt = S_START;
      S_START: begin
        if (w_sample && w_maj) w_state_nxt = S_IDLE;
        else if (w_bit_end)    w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_bit_idx == C_LAST_BIT))
          w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP: begin
        // Leave at the final sample point so a back-to-back start edge is not missed.
        if (w_sample && w_last_stop) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_s0        <= 1'b1;
      r_s1        <= 1'b1;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
      r_armed     <= 1'b1;
    end else begin
      if (r_state == S_IDLE || w_bit_end) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;

      if (r_state != S_IDLE) begin
        if (r_cnt == C_S0) r_s0 <= w_rx_s;
        if (r_cnt == C_S1) r_s1 <= w_rx_s;
      end

      case (r_state)
        S_IDLE: begin
          r_bit_idx   <= '0;
          r_stop_idx  <= 1'b0;
          r_frame_err <= 1'b0;
          r_par_err   <= 1'b0;
          if (w_rx_s) r_armed <= 1'b1;
        end
        S_DATA: begin
          if (w_sample)  r_shift   <= {w_maj, r_shift[DATA_WIDTH-1:1]};
          if (w_bit_end) r_bit_idx <= r_bit_idx + 1'b1;
        end
        S_PARITY: if (w_sample && (w_maj != w_par_exp)) r_par_err <= 1'b1;
        S_STOP: begin
          if (w_sample && !w_maj) r_frame_err <= 1'b1;
          if (w_bit_end)          r_stop_idx  <= 1'b1;
          // A framing error (e.g. break) must see the line high before the next frame.
          if (w_push)             r_armed     <= ~w_frame_err_fin;
        end
        default: ;
      endcase
    end
  end

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & rx_ready_i;
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {r_shift, w_frame_err_fin, r_par_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overrun <= w_push & w_full & ~w_pop;
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign rx_valid_o   = ~w_empty;
  assign rx_data_o    = w_empty ? '0 : w_head[EW-1:2];
  assign frame_err_o  = ~w_empty & w_head[1];
  assign parity_err_o = ~w_empty & w_head[0] & (PARITY != 0);
  assign overrun_o    = r_overrun;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance (a) and an 8E1 instance (b),
// both at 16 clocks per bit, with popped words captured by a negedge monitor.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, frame_a, frame_b, par_a, par_b;
  logic       ovr_a_o, ovr_b_o, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_WIDTH(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_a), .rx_data_o(data_a), .rx_valid_o(valid_a),
    .rx_ready_i(ready_a), .frame_err_o(frame_a), .parity_err_o(par_a),
    .overrun_o(ovr_a_o), .busy_o(busy_a));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_WIDTH(8),
                  .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_b), .rx_data_o(data_b), .rx_valid_o(valid_b),
    .rx_ready_i(ready_b), .frame_err_o(frame_b), .parity_err_o(par_b),
    .overrun_o(ovr_b_o), .busy_o(busy_b));

  // Popped words as {frame_err, parity_err, data}
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  int   ovr_a = 0;
  int   va_cycles = 0;
  logic prev_valid_a = 1'b0, prev_busy_a = 1'b0;
  logic busy_at_rise = 1'bx, busy_before_rise = 1'bx;

  always @(negedge clk) begin
    if (valid_a && ready_a) qa.push_back({frame_a, par_a, data_a});
    if (valid_b && ready_b) qb.push_back({frame_b, par_b, data_b});
    if (ovr_a_o) ovr_a++;
    if (valid_a) va_cycles++;
    if (valid_a && !prev_valid_a) begin
      busy_at_rise     = busy_a;
      busy_before_rise = prev_busy_a;
    end
    prev_valid_a = valid_a;
    prev_busy_a  = busy_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame, 16 clocks per bit; optional one-cycle inversion at (gbit, goff).
  task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                      input logic par, input logic stop, input int gbit, input int goff);
    logic [10:0] fr;
    int          n;
    fr    = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i+1] = d[i];
    n = 9;
    if (has_par) begin
      fr[n] = par;
      n++;
    end
    fr[n] = stop;
    n++;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 16; c++) begin
        set_rx(sel, (i == gbit && c == goff) ? ~fr[i] : fr[i]);
        @(negedge clk);
      end
    end
    set_rx(sel, 1'b1);
  endtask

  int base_q, base_v, base_o;

  initial begin
    // Reset state
    idle(3);
    chk("rst_valid_a", valid_a, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_ovr_a", ovr_a_o, 0);
    chk("rst_valid_b", valid_b, 0);
    rst_n = 1'b1;
    idle(5);

    // 1: 8N1 0xA5 with ready high
    base_q = qa.size();
    base_v = va_cycles;
    send(0, 8'hA5, 0, 0, 1, -1, 0);
    idle(20);
    chk("t1_count", qa.size() - base_q, 1);
    if (qa.size() > base_q) chk("t1_word", qa[base_q], {2'b00, 8'hA5});
    chk("t1_valid_cycles", va_cycles - base_v, 1);
    chk("t1_busy_at_valid", busy_at_rise, 0);
    chk("t1_busy_at_push", busy_before_rise, 1);

    // 2: even parity, 0x37 expects parity bit 1
    base_q = qb.size();
    send(1, 8'h37, 1, 0, 1, -1, 0);
    idle(20);
    send(1, 8'h37, 1, 1, 1, -1, 0);
    idle(20);
    chk("t2_count", qb.size() - base_q, 2);
    if (qb.size() > base_q + 1) begin
      chk("t2_bad_parity", qb[base_q], {2'b01, 8'h37});
      chk("t2_good_parity", qb[base_q+1], {2'b00, 8'h37});
    end

    // 3: framing error followed by a 40-bit break, then recovery
    base_q = qa.size();
    send(0, 8'h00, 0, 0, 0, -1, 0);
    rx_a = 1'b0;
    idle(640);
    rx_a = 1'b1;
    chk("t3_break_count", qa.size() - base_q, 1);
    if (qa.size() > base_q) chk("t3_break_word", qa[base_q], {2'b10, 8'h00});
    idle(32);
    send(0, 8'h55, 0, 0, 1, -1, 0);
    idle(20);
    chk("t3_total", qa.size() - base_q, 2);
    if (qa.size() > base_q + 1) chk("t3_recover", qa[base_q+1], {2'b00, 8'h55});

    // 4: start glitch rejected; one-cycle inversion inside data bit 3
    base_q = qa.size();
    rx_a = 1'b0;
    idle(4);
    rx_a = 1'b1;
    idle(40);
    chk("t4_glitch_none", qa.size() - base_q, 0);
    chk("t4_glitch_busy", busy_a, 0);
    send(0, 8'h0F, 0, 0, 1, 4, 9);
    idle(20);
    chk("t4_inv_count", qa.size() - base_q, 1);
    if (qa.size() > base_q) chk("t4_inv_word", qa[base_q], {2'b00, 8'h0F});

    // 5: overrun with a full FIFO, then drain
    ready_a = 1'b0;
    base_o = ovr_a;
    for (int i = 1; i <= 4; i++) send(0, 8'(i), 0, 0, 1, -1, 0);
    idle(20);
    chk("t5_no_ovr_yet", ovr_a - base_o, 0);
    send(0, 8'h05, 0, 0, 1, -1, 0);
    idle(20);
    chk("t5_ovr_pulses", ovr_a - base_o, 1);
    chk("t5_head_stable", data_a, 8'h01);
    chk("t5_valid_full", valid_a, 1);
    base_q = qa.size();
    ready_a = 1'b1;
    idle(10);
    chk("t5_drain_count", qa.size() - base_q, 4);
    for (int i = 0; i < 4; i++)
      if (qa.size() > base_q + i) chk("t5_drain_word", qa[base_q+i], {2'b00, 8'(i + 1)});
    chk("t5_valid_after", valid_a, 0);

    // 6: reset during data bit 4
    ready_a = 1'b0;
    send(0, 8'h99, 0, 0, 1, -1, 0);
    idle(20);
    chk("t6_pre_valid", valid_a, 1);
    rx_a = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      rx_a = i[0];
      idle(16);
    end
    rx_a = 1'b0;
    idle(8);
    rst_n = 1'b0;
    rx_a  = 1'b1;
    idle(3);
    chk("t6_rst_valid", valid_a, 0);
    chk("t6_rst_data", data_a, 0);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_flags", {frame_a, par_a, ovr_a_o}, 0);
    rst_n = 1'b1;
    idle(20);
    chk("t6_empty_after", valid_a, 0);
    ready_a = 1'b1;
    base_q = qa.size();
    send(0, 8'hC3, 0, 0, 1, -1, 0);
    idle(20);
    chk("t6_count", qa.size() - base_q, 1);
    if (qa.size() > base_q) chk("t6_word", qa[base_q], {2'b00, 8'hC3});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
